// File: rtl/python_bitslip_align.sv
// ---------------------------------------------------------------------------
// python_bitslip_align
//
// Per-lane word-alignment controller for the PYTHON sensor LVDS receive path.
// While the sensor streams its training word, each lane is checked and its
// deserializer is slipped one bit at a time until the lane word matches the
// training word for MATCH_COUNT consecutive valid words. Once that happens
// the lane reports lock. A lane reports failure if MAX_SLIPS bitslips are
// not enough. Every lane runs its own copy of the same FSM.
//
// Ports:
//   clk         deserializer word clock (python_clk domain)
//   reset       synchronous, active-high reset
//   enable      level; 1 = run alignment, 0 = hold all lanes idle
//   restart     one-cycle pulse; restart alignment on every lane
//   s_valid     s_data carries a valid word this cycle
//   s_data      lane i is bits [i*DATA_BITS +: DATA_BITS]
//   bitslip     one-cycle bitslip pulse per lane
//   aligned     lane i is locked
//   error       lane i has failed
//   all_aligned every lane is locked
//   busy        at least one lane is still settling, checking or slipping
//   slip_count  bitslips issued per lane since the last start
// ---------------------------------------------------------------------------
module python_bitslip_align #(
    parameter int unsigned             LANES         = 4,
    parameter int unsigned             DATA_BITS     = 10,
    parameter logic [DATA_BITS-1:0]    TRAIN_PATTERN = 10'h3a6,
    parameter int unsigned             SETTLE_CYCLES = 8,
    parameter int unsigned             MATCH_COUNT   = 16,
    parameter int unsigned             MAX_SLIPS     = 20,
    parameter int unsigned             SLIP_BITS     = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           restart,
    input  logic                           s_valid,
    input  logic [LANES*DATA_BITS-1:0]     s_data,
    output logic [LANES-1:0]               bitslip,
    output logic [LANES-1:0]               aligned,
    output logic [LANES-1:0]               error,
    output logic                           all_aligned,
    output logic                           busy,
    output logic [LANES*SLIP_BITS-1:0]     slip_count
);

    localparam int unsigned WAIT_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned MATCH_W = $clog2(MATCH_COUNT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CHECK,
        ST_SLIP,
        ST_LOCKED,
        ST_FAIL
    } state_t;

    // Next-state flags per lane, so the shared status bits can be registered
    // in the same cycle as the per-lane state they summarise.
    logic [LANES-1:0] next_locked;
    logic [LANES-1:0] next_busy;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        state_t                 state;
        state_t                 state_nxt;
        logic [WAIT_W-1:0]      wait_cnt;
        logic [MATCH_W-1:0]     match_cnt;
        logic [SLIP_BITS-1:0]   slip_cnt;
        logic                   bitslip_q;
        logic                   aligned_q;
        logic                   error_q;
        logic                   word_ok;

        assign word_ok = (s_data[i*DATA_BITS +: DATA_BITS] == TRAIN_PATTERN);

        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        always_comb begin
            state_nxt = state;
            if (!enable || restart) begin
                state_nxt = ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE:   state_nxt = ST_SETTLE;
                    ST_SETTLE: if (wait_cnt == '0) state_nxt = ST_CHECK;
                    ST_CHECK: begin
                        // Invalid words neither count as matches nor break a run.
                        if (s_valid) begin
                            if (word_ok) begin
                                if (match_cnt == MATCH_W'(MATCH_COUNT - 1))
                                    state_nxt = ST_LOCKED;
                            end else if (slip_cnt == SLIP_BITS'(MAX_SLIPS)) begin
                                state_nxt = ST_FAIL;
                            end else begin
                                state_nxt = ST_SLIP;
                            end
                        end
                    end
                    ST_SLIP:   state_nxt = ST_SETTLE;
                    default:   state_nxt = state;  // LOCKED / FAIL hold
                endcase
            end
        end

        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values regardless of statement order.
        always_ff @(posedge clk) begin
            if (reset) begin
                state     <= ST_IDLE;
                wait_cnt  <= '0;
                match_cnt <= '0;
                slip_cnt  <= '0;
                bitslip_q <= 1'b0;
                aligned_q <= 1'b0;
                error_q   <= 1'b0;
            end else begin
                state     <= state_nxt;
                bitslip_q <= (state_nxt == ST_SLIP);
                aligned_q <= (state_nxt == ST_LOCKED);
                error_q   <= (state_nxt == ST_FAIL);

                if (state_nxt == ST_IDLE) begin
                    wait_cnt  <= '0;
                    match_cnt <= '0;
                    slip_cnt  <= '0;
                end else begin
                    case (state)
                        ST_IDLE: wait_cnt <= WAIT_W'(SETTLE_CYCLES - 1);
                        ST_SETTLE: begin
                            if (wait_cnt != '0) wait_cnt  <= wait_cnt - WAIT_W'(1);
                            else                match_cnt <= '0;
                        end
                        ST_CHECK: begin
                            if (s_valid && word_ok) match_cnt <= match_cnt + MATCH_W'(1);
                        end
                        ST_SLIP: begin
                            slip_cnt <= slip_cnt + SLIP_BITS'(1);
                            wait_cnt <= WAIT_W'(SETTLE_CYCLES - 1);
                        end
                        default: ;
                    endcase
                end
            end
        end

        assign next_locked[i] = (state_nxt == ST_LOCKED);
        assign next_busy[i]   = (state_nxt inside {ST_SETTLE, ST_CHECK, ST_SLIP});

        assign bitslip[i]                           = bitslip_q;
        assign aligned[i]                           = aligned_q;
        assign error[i]                             = error_q;
        assign slip_count[i*SLIP_BITS +: SLIP_BITS] = slip_cnt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            all_aligned <= 1'b0;
            busy        <= 1'b0;
        end else begin
            all_aligned <= &next_locked;
            busy        <= |next_busy;
        end
    end

endmodule

// File: doc/python_bitslip_align.md
Name: python_bitslip_align

Overview:
- Per-lane word-alignment controller for the PYTHON sensor LVDS receive path.
- Watches the deserialized 10-bit words of each data lane (and the sync lane, when instantiated as a lane) while the sensor sends its training pattern.
- Issues single-cycle bitslip pulses to the deserializer until every lane matches the training word, then reports lock or failure.
- Sits between the ISERDES/bitslip primitives and the register block (CTL_BITSLIP enable/restart, status readback), in the python_clk domain.

Parameters:
- LANES, 4, number of independently aligned lanes.
- DATA_BITS, 10, word width per lane.
- TRAIN_PATTERN, 10'h3a6, training word expected on every lane.
- SETTLE_CYCLES, 8, clk cycles waited after enable or after each bitslip before words are checked (covers deserializer pipeline).
- MATCH_COUNT, 16, consecutive matching valid words required to declare lock.
- MAX_SLIPS, 20, bitslips allowed per lane before declaring failure.
- SLIP_BITS, 5, width of each slip counter; must satisfy 2^SLIP_BITS > MAX_SLIPS.

Ports:
- clk, input, 1, deserializer word clock (python_clk domain).
- reset, input, 1, synchronous active-high reset.
- enable, input, 1, level; 1 = run alignment, 0 = hold all lanes idle.
- restart, input, 1, single-cycle pulse; restart alignment on all lanes.
- s_valid, input, 1, s_data word valid this cycle.
- s_data, input, LANES*DATA_BITS, lane i occupies bits [i*DATA_BITS +: DATA_BITS].
- bitslip, output, LANES, one-cycle bitslip pulse per lane.
- aligned, output, LANES, lane i is in LOCKED.
- error, output, LANES, lane i is in FAIL.
- all_aligned, output, 1, AND of aligned.
- busy, output, 1, any lane in SETTLE, CHECK or SLIP.
- slip_count, output, LANES*SLIP_BITS, bitslips issued per lane since the last start.

Behaviour:
- Clock and reset: one clock (clk); reset synchronous, active-high.
- All outputs registered; every output resets to 0.
- Each lane runs an identical, independent FSM. Shared inputs: enable, restart, s_valid.
- States: IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL.

FSM transitions:
- IDLE:
  - slip_cnt = 0.
  - If enable=1 and restart=0 → SETTLE, wait_cnt = SETTLE_CYCLES-1.
- SETTLE:
  - wait_cnt decrements every clk, regardless of s_valid.
  - At 0 → CHECK, match_cnt = 0.
- CHECK (acts only when s_valid=1):
  - Lane word == TRAIN_PATTERN: match_cnt++. When the incremented value reaches MATCH_COUNT → LOCKED.
  - Mismatch and slip_cnt == MAX_SLIPS → FAIL.
  - Mismatch otherwise → SLIP.
- SLIP:
  - bitslip[i] = 1 for exactly this one cycle.
  - slip_cnt++.
  - → SETTLE with wait_cnt = SETTLE_CYCLES-1.
- LOCKED: aligned[i] = 1; held until enable=0, restart or reset. Later mismatches are ignored.
- FAIL: error[i] = 1; held until enable=0, restart or reset.

Priority and control rules:
- Priority: reset > (enable=0 or restart=1) → IDLE > normal transitions.
- restart=1 with enable=1 → IDLE for one cycle, then SETTLE. Counters cleared in that IDLE cycle.
- slip_count holds its value in LOCKED and FAIL. It clears only on IDLE entry.

Latency and data-valid rules:
- bitslip pulses on a lane are at least SETTLE_CYCLES+2 clk apart.
- A lane already matching at start locks after SETTLE_CYCLES + MATCH_COUNT valid cycles (+1 registered output).
- s_valid=0 cycles stall CHECK and do not reset match_cnt.
- A single mismatch in CHECK discards partial matches (match_cnt restarts at 0 after the following SETTLE).

Other:
- all_aligned and busy are registered from next-state values, so they change in the same cycle as aligned, error and state.
- enable deasserted mid-SLIP: the bitslip pulse already output completes. No further pulse is issued.

Test Plan:
- Aligned at start: reset 4 cycles, enable=1, s_valid=1, all lanes 10'h3a6 → no bitslip; all_aligned=1 at cycle 8+16+1 after enable; slip_count all 0.
- Per-lane offsets: bench model rotates each lane word left by 1 per bitslip; initial offsets 0/3/7/9 slips → aligned per lane; slip_count = 0,3,7,9; bitslip pulses spaced ≥10 cycles; all_aligned after lane 3 locks.
- Unalignable lane: lane 2 constant 10'h000 → lane 2 error=1 after exactly 20 bitslips, slip_count[2]=20, other lanes aligned=1, all_aligned=0, busy=0.
- Glitch during CHECK: lane 1 correct but one mismatch at match_cnt=10 → one bitslip issued on lane 1, re-settle, relock; slip_count[1]=1.
- Stalls: s_valid toggling 1/0 each cycle, aligned data → lock after 16 valid words (~8+32 cycles); match_cnt not cleared by gaps.
- Restart/disable mid-operation: restart pulse while lane 0 in SETTLE at slip 4 → slip_count cleared to 0, IDLE one cycle, re-align. enable=0 while LOCKED → aligned=0, error=0, busy=0 next cycle. Reset asserted mid-SLIP → all outputs 0 next cycle.
